// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: control inputs and display pin outputs of the 7-segment scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with frame-synchronous
// display update, anti-ghost blanking, hex/decimal decode and leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_MODE     = 1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 5 * NUM_DIGITS;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // pending/display hold {nibbles, decimal points}
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_pend;
    logic [DW-1:0]         r_disp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_tc;
    logic                  w_last;
    logic                  w_frame;
    logic                  w_blank;
    logic [3:0]            w_nib;
    logic [NUM_DIGITS-1:0] w_zero_nib;
    logic                  w_lz;
    logic [6:0]            w_seg;

    assign w_tc    = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_last  = r_idx == IW'(NUM_DIGITS - 1);
    assign w_frame = bus.enable && w_tc && w_last;
    assign w_blank = !bus.enable || r_cnt < CW'(BLANK_CYCLES);
    assign w_nib   = 4'(r_disp[DW-1:NUM_DIGITS] >> {r_idx, 2'b00});

    always_comb begin
        w_zero_nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) w_zero_nib[k] = ~|r_disp[NUM_DIGITS+4*k +: 4];
    end

    // blank when this digit and every more-significant digit is zero; digit 0 always shows
    assign w_lz  = bus.blank_lz && r_idx != '0 &&
                   &(w_zero_nib | ((NUM_DIGITS'(1) << r_idx) - NUM_DIGITS'(1)));
    assign w_seg = (w_lz || (HEX_MODE == 0 && w_nib > 4'd9)) ? 7'h7F : SEG_LUT[w_nib];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_disp       <= '0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= (!bus.enable || w_tc) ? '0 : r_cnt + 1'b1;
            r_idx        <= !bus.enable ? '0 : w_tc ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
            r_pend       <= bus.load ? {bus.value, bus.dp_in} : r_pend;
            r_disp       <= w_frame ? (bus.load ? {bus.value, bus.dp_in} : r_pend) : r_disp;
            r_frame_done <= w_frame;
            r_an         <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
            r_seg        <= w_blank ? 7'h7F : w_seg;
            r_dp         <= w_blank || !r_disp[r_idx];
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench driving a hex-mode and a decimal-mode driver in lockstep.
module tb_seg7_scan_driver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       mon_on = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [23:0] q[$];

    seg7_scan_driver_if #(.NUM_DIGITS(4)) b0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(4)) b1 ();

    assign b1.enable   = b0.enable;
    assign b1.load     = b0.load;
    assign b1.value    = b0.value;
    assign b1.dp_in    = b0.dp_in;
    assign b1.blank_lz = b0.blank_lz;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0)) dut_dec (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // each lit cycle consumes one expected {an,seg,dp} pair (hex dut, dec dut)
    always @(negedge clk) begin
        if (mon_on) begin
            if (b0.an != 4'hF || b1.an != 4'hF) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scan_extra: got an=%h/%h with no expected digit at %0t", b0.an, b1.an, $time);
                end else begin
                    logic [23:0] e;
                    e = q.pop_front();
                    chk("scan_hex", {b0.an, b0.seg, b0.dp}, {20'd0, e[23:12]});
                    chk("scan_dec", {b1.an, b1.seg, b1.dp}, {20'd0, e[11:0]});
                end
            end else begin
                chk("blank_hex", {b0.seg, b0.dp}, 32'hFF);
                chk("blank_dec", {b1.seg, b1.dp}, 32'hFF);
            end
        end
    end

    task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
        @(posedge clk); #1;
        b0.value = v;
        b0.dp_in = d;
        b0.load  = 1'b1;
        @(posedge clk); #1;
        b0.load  = 1'b0;
    endtask

    task automatic sync_fd(input string name);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!b0.frame_done && n < 64);
        if (!b0.frame_done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no frame_done expected one within 64 cycles", name);
        end
    endtask

    // digit values packed {d3,d2,d1,d0}; dpv is dp_in (1 = lit)
    task automatic frame(input string name, input logic [27:0] sh, input logic [27:0] sd, input logic [3:0] dpv);
        int n = 0;
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++)
            repeat (3) q.push_back({~(4'b0001 << k), sh[7*k +: 7], ~dpv[k], ~(4'b0001 << k), sd[7*k +: 7], ~dpv[k]});
        mon_on = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!b0.frame_done && n < 64);
        if (!b0.frame_done) begin
            checks++;
            errors++;
            $display("FAIL %s_end: got no frame_done expected one within 64 cycles", name);
        end
        @(negedge clk); #1;
        mon_on = 1'b0;
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        logic [3:0] ren_an [6] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
        logic       ren_dp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         n;
        logic       bad;
        rst_n       = 1'b1;
        b0.enable   = 1'b0;
        b0.load     = 1'b0;
        b0.value    = '0;
        b0.dp_in    = '0;
        b0.blank_lz = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_an", b0.an, 4'hF);
        chk("reset_seg", b0.seg, 7'h7F);
        chk("reset_dp", b0.dp, 1);
        chk("reset_fd", b0.frame_done, 0);
        chk("reset_an_dec", b1.an, 4'hF);
        rst_n     = 1'b1;
        b0.enable = 1'b1;

        drive_load(16'h1234, 4'h0);
        sync_fd("first_frame");
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!b0.frame_done && n < 64);
        chk("frame_period", n, 16);
        frame("scan_1234", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'h0);

        drive_load(16'hABCD, 4'h0);
        sync_fd("hex_sync");
        frame("hex_abcd", {7'h08, 7'h03, 7'h46, 7'h21}, {4{7'h7F}}, 4'h0);

        b0.blank_lz = 1'b1;
        drive_load(16'h0070, 4'h0);
        sync_fd("lz_sync");
        frame("lz_0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'h0);

        drive_load(16'h0000, 4'h0);
        sync_fd("zero_sync");
        fork
            frame("lz_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0);
            begin
                repeat (6) @(posedge clk);
                #1;
                b0.value = 16'h1111;
                b0.load  = 1'b1;
                @(posedge clk); #1;
                b0.load  = 1'b0;
            end
        join
        fork
            frame("tear_1111", {4{7'h79}}, {4{7'h79}}, 4'h0);
            begin
                repeat (15) @(posedge clk);
                #1;
                b0.value = 16'h2222;
                b0.load  = 1'b1;
                @(posedge clk); #1;
                b0.load  = 1'b0;
            end
        join
        frame("bypass_2222", {4{7'h24}}, {4{7'h24}}, 4'h0);

        drive_load(16'h2222, 4'b0001);
        sync_fd("dp_sync");
        frame("dp_2222", {4{7'h24}}, {4{7'h24}}, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_disable_an", b0.an, 4'hE);
        b0.enable = 1'b0;
        @(posedge clk); #1;
        chk("disable_an", b0.an, 4'hF);
        chk("disable_seg", b0.seg, 7'h7F);
        chk("disable_dp", b0.dp, 1);
        drive_load(16'h4444, 4'h0);
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (b0.an != 4'hF || b0.frame_done) bad = 1'b1;
        end
        chk("disabled_dark", bad, 0);
        b0.enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("reenable_an", b0.an, ren_an[i]);
            chk("reenable_dp", b0.dp, ren_dp[i]);
        end
        sync_fd("reenable_sync");
        frame("load_while_off", {4{7'h19}}, {4{7'h19}}, 4'h0);

        repeat (6) @(posedge clk);
        #1;
        chk("prereset_an", b0.an, 4'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_an", b0.an, 4'hF);
        chk("async_reset_seg", b0.seg, 7'h7F);
        chk("async_reset_dp", b0.dp, 1);
        chk("async_reset_fd", b0.frame_done, 0);
        repeat (2) @(posedge clk);
        #1;
        b0.blank_lz = 1'b0;
        rst_n       = 1'b1;
        sync_fd("post_reset_sync");
        frame("reset_cleared", {4{7'h40}}, {4{7'h40}}, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected one by %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
